// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for NUM_DIGITS common-cathode digits
// sharing a single external BCD-to-7-segment decoder.
//
// A frame of packed BCD digits is double-buffered. The producer writes the pending
// buffer via a valid/ready handshake, and the active buffer is swapped only at a frame
// boundary. Each digit gets BLANK_GAP dark cycles followed by REFRESH_DIV lit cycles.
// Leading-zero suppression is optional.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   load_valid    producer offers a new frame on load_data
//   load_ready    controller can accept a frame (no pending frame held)
//   load_data     packed BCD frame, digit 0 in [3:0]
//   blank_lz      1 = suppress leading zeros (sampled live)
//   dec_in        BCD digit presented to the shared decoder
//   dec_out       segments returned by the decoder, {a..g}
//   seg_out       segment drive, active-high
//   dig_en        one-hot digit enable, or all zero while dark
//   frame_start   one-cycle pulse on the first cycle of digit 0's period
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned BLANK_GAP   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    blank_lz,
  output logic [3:0]              dec_in,
  input  logic [6:0]              dec_out,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_start
);

  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned CntMax = (REFRESH_DIV > BLANK_GAP) ? REFRESH_DIV : BLANK_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] ShowLast  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_GAP > 0) ? BLANK_GAP - 1 : 0);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pending_valid_q, pending_valid_d;

  logic wrap;
  logic upper_zero;
  logic blank_this;
  logic period_first;

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q + 1'b1;
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    wrap            = 1'b0;

    unique case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StShow;
          cnt_d   = '0;
        end
      end
      StShow: begin
        if (cnt_q == ShowLast) begin
          cnt_d = '0;
          wrap  = (idx_q == IdxLast);
          idx_d = wrap ? '0 : idx_q + 1'b1;
          if (BLANK_GAP == 0) begin
            state_d = StShow;
          end else begin
            state_d = StBlank;
          end
        end
      end
    endcase

    // Accept needs an empty pending buffer, commit needs a full one, so they never collide.
    if (load_valid && !pending_valid_q) begin
      pending_d       = load_data;
      pending_valid_d = 1'b1;
    end
    if (wrap && pending_valid_q) begin
      active_d        = pending_q;
      pending_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (BLANK_GAP == 0) begin
        state_q <= StShow;
      end else begin
        state_q <= StBlank;
      end
      idx_q           <= '0;
      cnt_q           <= '0;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (j >= 32'(idx_q) && active_q[4*j +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end
  end

  assign blank_this = blank_lz && (idx_q != '0) && upper_zero;

  // First cycle of digit 0's period: the gap if there is one, else the lit phase.
  assign period_first = (idx_q == '0) && (cnt_q == '0) &&
                        ((BLANK_GAP == 0) ? (state_q == StShow) : (state_q == StBlank));

  assign load_ready = !pending_valid_q;
  // Driven in both states so the decoder output is settled before the digit lights.
  assign dec_in     = active_q[{idx_q, 2'b00} +: 4];

  // The reset state is also the first cycle of a frame; gating with rst_n keeps the
  // pins dark and frame_start low while reset is held.
  assign dig_en      = (rst_n && state_q == StShow) ? (NUM_DIGITS'(1) << idx_q) : '0;
  assign seg_out     = (rst_n && state_q == StShow && !blank_this) ? dec_out : 7'b0;
  assign frame_start = rst_n && period_first;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_GAP=1).
// The reference model tracks time since reset as a plain cycle count and derives the
// lit digit and phase from it arithmetically. Alongside it are a table of known
// frames with their expected segment patterns and a few hand-written corner sequences.
module tb_seg_scan_ctrl;

  localparam int ND  = 4;
  localparam int RD  = 4;
  localparam int BG  = 1;
  localparam int SLT = RD + BG;
  localparam int PER = ND * SLT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic        blank_lz = 1'b0;
  logic        load_ready;
  logic [3:0]  dec_in;
  logic [6:0]  dec_out;
  logic [6:0]  seg_out;
  logic [3:0]  dig_en;
  logic        frame_start;

  always #5 clk = ~clk;

  // Shared BCD decoder, segments {a..g}; non-BCD codes give all segments off.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: seg7 = 7'b1111110;
      4'd1: seg7 = 7'b0110000;
      4'd2: seg7 = 7'b1101101;
      4'd3: seg7 = 7'b1111001;
      4'd4: seg7 = 7'b0110011;
      4'd5: seg7 = 7'b1011011;
      4'd6: seg7 = 7'b1011111;
      4'd7: seg7 = 7'b1110000;
      4'd8: seg7 = 7'b1111111;
      4'd9: seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  assign dec_out = seg7(dec_in);

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .BLANK_GAP  (BG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_lz   (blank_lz),
    .dec_in     (dec_in),
    .dec_out    (dec_out),
    .seg_out    (seg_out),
    .dig_en     (dig_en),
    .frame_start(frame_start)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: cycles since reset release plus the two frame buffers.
  int          t;
  logic [15:0] m_active;
  logic [15:0] m_pending;
  logic        m_pv;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    t         = 0;
    m_active  = 16'h0;
    m_pending = 16'h0;
    m_pv      = 1'b0;
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    if ((t % PER) == PER - 1 && m_pv) begin
      m_active = m_pending;
      m_pv     = 1'b0;
    end else if (load_valid && !m_pv) begin
      m_pending = load_data;
      m_pv      = 1'b1;
    end
    t++;
  endtask

  task automatic check_outputs();
    int          p, d, ph;
    logic        show, lz;
    logic [3:0]  dg, ed;
    logic [6:0]  es;
    if (!rst_n) begin
      cmp("rst_seg_out", 32'(seg_out), 32'(0));
      cmp("rst_dig_en", 32'(dig_en), 32'(0));
      cmp("rst_load_ready", 32'(load_ready), 32'(1));
      cmp("rst_dec_in", 32'(dec_in), 32'(0));
      cmp("rst_frame_start", 32'(frame_start), 32'(0));
      return;
    end
    p    = t % PER;
    d    = p / SLT;
    ph   = p % SLT;
    show = (ph >= BG);
    dg   = m_active[4*d +: 4];
    lz   = blank_lz && (d != 0) && ((m_active >> (4*d)) == 16'h0);
    ed   = show ? 4'(1 << d) : 4'd0;
    es   = (show && !lz) ? seg7(dg) : 7'd0;
    cmp("seg_out", 32'(seg_out), 32'(es));
    cmp("dig_en", 32'(dig_en), 32'(ed));
    cmp("load_ready", 32'(load_ready), 32'(!m_pv));
    cmp("dec_in", 32'(dec_in), 32'(dg));
    cmp("frame_start", 32'(frame_start), 32'(p == 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic load_frame(input logic [15:0] f);
    bit ok;
    ok         = 1'b0;
    load_data  = f;
    load_valid = 1'b1;
    for (int i = 0; i < 3 * PER && !ok; i++) begin
      ok = !m_pv;
      step();
    end
    load_valid = 1'b0;
    if (!ok) cmp("load_accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_commit();
    int n;
    n = 0;
    while (m_pv && n < 3 * PER) begin
      step();
      n++;
    end
    if (m_pv) cmp("commit_timeout", 32'(0), 32'(1));
  endtask

  typedef struct packed {
    logic [15:0] frame;
    logic        lz;
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, gap;
    bit seen;

    vecs[0] = '{16'h1234, 1'b0, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
    vecs[1] = '{16'h0070, 1'b1, {7'b0000000, 7'b0000000, 7'b1110000, 7'b1111110}};
    vecs[2] = '{16'h0070, 1'b0, {7'b1111110, 7'b1111110, 7'b1110000, 7'b1111110}};
    vecs[3] = '{16'h00A9, 1'b0, {7'b1111110, 7'b1111110, 7'b0000000, 7'b1111011}};
    vecs[4] = '{16'h00A9, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111011}};
    vecs[5] = '{16'h1111, 1'b0, {7'b0110000, 7'b0110000, 7'b0110000, 7'b0110000}};
    vecs[6] = '{16'h2222, 1'b0, {7'b1101101, 7'b1101101, 7'b1101101, 7'b1101101}};
    vecs[7] = '{16'h0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};

    // Reset held, then released: frame_start on the first cycle, digit 0 shows "0".
    model_reset();
    @(negedge clk);
    check_outputs();
    step();
    release_reset();
    cmp("first_cycle_frame_start", 32'(frame_start), 32'(1));
    for (int i = 0; i < PER; i++) step();

    // Table of frames: load, wait for commit, then check each digit's last lit cycle.
    for (int v = 0; v < 8; v++) begin
      blank_lz = vecs[v].lz;
      load_frame(vecs[v].frame);
      wait_commit();
      for (int k = 0; k < PER; k++) begin
        if (k % SLT == SLT - 1) begin
          cmp($sformatf("vec%0d_seg_d%0d", v, k / SLT), 32'(seg_out),
              32'(vecs[v].segs[7*(k/SLT) +: 7]));
          cmp($sformatf("vec%0d_dig_d%0d", v, k / SLT), 32'(dig_en), 32'(1 << (k / SLT)));
        end
        step();
      end
    end
    blank_lz = 1'b0;

    // Back-to-back loads with load_valid held: the second waits for the first commit.
    load_data  = 16'h1111;
    load_valid = 1'b1;
    n = 0;
    while (!m_pv && n < 2 * PER) begin step(); n++; end
    load_data = 16'h2222;
    n = 0;
    while (m_pv && n < 3 * PER) begin step(); n++; end
    cmp("b2b_first_committed", 32'(m_active), 32'h1111);
    step();
    cmp("b2b_second_accepted_next_cycle", 32'(load_ready), 32'(0));
    load_valid = 1'b0;
    wait_commit();
    cmp("b2b_second_committed", 32'(m_active), 32'h2222);

    // Frame period measured from the DUT's own frame_start pulses.
    n = 0;
    while (!frame_start && n < 2 * PER) begin step(); n++; end
    gap  = 0;
    seen = 1'b0;
    for (int i = 0; i < 2 * PER && !seen; i++) begin
      step();
      gap++;
      seen = frame_start;
    end
    cmp("frame_period", 32'(gap), 32'(PER));

    // Randomized traffic, including non-BCD digits and live blank_lz changes.
    for (int i = 0; i < 800; i++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 16'($urandom) >> (4 * $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      step();
    end
    load_valid = 1'b0;
    blank_lz   = 1'b0;
    wait_commit();

    // Reset during SHOW of digit 2 with a frame pending: pending frame is discarded.
    n = 0;
    while ((t % PER) != 0 && n < 2 * PER) begin step(); n++; end
    load_frame(16'h5678);
    n = 0;
    while ((t % PER) != 3 * SLT - 2 && n < 2 * PER) begin step(); n++; end
    cmp("midreset_pending_held", 32'(load_ready), 32'(0));
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    step();
    step();
    release_reset();
    for (int i = 0; i < 2 * PER; i++) step();
    cmp("midreset_ready_after", 32'(load_ready), 32'(1));
    cmp("midreset_frame_zero", 32'(dec_in), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
